fetch_sequencer: RTL and testbench

Program-counter and fetch controller for the 64 x 16-bit instruction memory. It addresses the memory's combinational read port, latches each instruction into a single-entry output slot, and hands it to decode over a valid/ready handshake. It also applies jump redirects from execute, stops on a halt request, and keeps fetch statistics.

---
 rtl/fetch_sequencer.sv | 133 +++++++++++++
 tb/tb_fetch_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_sequencer: program counter and single-slot fetch stage with         |
// | redirect, halt and fetch statistics.                                      |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_sequencer #(
  parameter int                 ADDR_W   = 6,
  parameter int                 INSTR_W  = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  output logic [ADDR_W-1:0]   o_imem_addr,
  input  logic [INSTR_W-1:0]  i_imem_data,
  output logic [INSTR_W-1:0]  o_instr_out,
  output logic [ADDR_W-1:0]   o_instr_pc,
  output logic                o_instr_valid,
  input  logic                i_instr_ready,
  input  logic                i_redirect_valid,
  input  logic [ADDR_W-1:0]   i_redirect_pc,
  input  logic                i_halt_req,
  output logic                o_running,
  output logic                o_pc_wrapped,
  output logic [15:0]         o_fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_PC_MAX    = '1;
  localparam logic [ADDR_W-1:0] c_PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]       c_COUNT_MAX = 16'hFFFF;

  state_t               r_state,    w_state_nxt;
  logic [ADDR_W-1:0]    r_pc,       w_pc_nxt;
  logic [INSTR_W-1:0]   r_instr,    w_instr_nxt;
  logic [ADDR_W-1:0]    r_instr_pc, w_instr_pc_nxt;
  logic                 r_valid,    w_valid_nxt;
  logic                 r_wrapped,  w_wrapped_nxt;
  logic [15:0]          r_count,    w_count_nxt;

  logic w_load;
  logic w_accept;

  // The slot refills when empty or when decode drains it this cycle.
  assign w_load   = ~r_valid | i_instr_ready;
  assign w_accept = r_valid & i_instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_wrapped  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_wrapped  <= w_wrapped_nxt;
      r_count    <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    w_wrapped_nxt  = r_wrapped;
    w_count_nxt    = r_count;

    // An accepted instruction counts even if the same cycle flushes the slot.
    if (w_accept && (r_count != c_COUNT_MAX)) begin
      w_count_nxt = r_count + 16'd1;
    end

    case (r_state)
      S_IDLE, S_HALTED: begin
        w_valid_nxt = 1'b0;
        if (i_start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = RESET_PC;
          if (r_state == S_IDLE) begin
            w_wrapped_nxt = 1'b0;
            w_count_nxt   = '0;
          end
        end
      end
      S_RUN: begin
        if (i_halt_req) begin
          w_state_nxt = S_HALTED;
          w_valid_nxt = 1'b0;
        end else if (i_redirect_valid) begin
          w_valid_nxt = 1'b0;
          w_pc_nxt    = i_redirect_pc;
        end else if (w_load) begin
          w_instr_nxt    = i_imem_data;
          w_instr_pc_nxt = r_pc;
          w_valid_nxt    = 1'b1;
          w_pc_nxt       = r_pc + c_PC_ONE;
          if (r_pc == c_PC_MAX) begin
            w_wrapped_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign o_imem_addr   = r_pc;
  assign o_instr_out   = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = r_valid;
  assign o_running     = (r_state == S_RUN);
  assign o_pc_wrapped  = r_wrapped;
  assign o_fetch_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_sequencer: table-driven bench with a small instruction memory.   |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instr_out;
  logic [5:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [5:0]  redirect_pc;
  logic        halt_req;
  logic        running;
  logic        pc_wrapped;
  logic [15:0] fetch_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] memw(input logic [5:0] a);
    return {4'hC, a, a};
  endfunction

  assign imem_data = memw(imem_addr);

  fetch_sequencer #(.ADDR_W(6), .INSTR_W(16), .RESET_PC(6'd0)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (start),
    .o_imem_addr      (imem_addr),
    .i_imem_data      (imem_data),
    .o_instr_out      (instr_out),
    .o_instr_pc       (instr_pc),
    .o_instr_valid    (instr_valid),
    .i_instr_ready    (instr_ready),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_halt_req       (halt_req),
    .o_running        (running),
    .o_pc_wrapped     (pc_wrapped),
    .o_fetch_count    (fetch_count)
  );

  typedef struct {
    logic        start;
    logic        ready;
    logic        redir;
    logic [5:0]  rpc;
    logic        halt;
    logic        e_valid;
    logic [5:0]  e_ipc;
    logic [5:0]  e_pc;
    logic        e_run;
    logic        e_wrap;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 29;
  vec_t vt [NV];

  function automatic vec_t mk(input logic st, input logic rd, input logic rv,
                              input logic [5:0] rp, input logic hl,
                              input logic ev, input logic [5:0] eipc,
                              input logic [5:0] epc, input logic er,
                              input logic ew, input logic [15:0] ec);
    vec_t v;
    v.start = st; v.ready = rd; v.redir = rv; v.rpc = rp; v.halt = hl;
    v.e_valid = ev; v.e_ipc = eipc; v.e_pc = epc; v.e_run = er;
    v.e_wrap = ew; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              st rd rv rpc  hl  ev ipc  pc   run wr cnt
    vt[0]  = mk(1, 1, 0, 6'd0, 0, 0, 6'd0, 6'd0, 1, 0, 16'd0);
    vt[1]  = mk(0, 1, 0, 6'd0, 0, 1, 6'd0, 6'd1, 1, 0, 16'd0);
    vt[2]  = mk(0, 1, 0, 6'd0, 0, 1, 6'd1, 6'd2, 1, 0, 16'd1);
    vt[3]  = mk(0, 1, 0, 6'd0, 0, 1, 6'd2, 6'd3, 1, 0, 16'd2);
    vt[4]  = mk(0, 1, 0, 6'd0, 0, 1, 6'd3, 6'd4, 1, 0, 16'd3);
    vt[5]  = mk(0, 1, 0, 6'd0, 0, 1, 6'd4, 6'd5, 1, 0, 16'd4);
    vt[6]  = mk(0, 0, 0, 6'd0, 0, 1, 6'd4, 6'd5, 1, 0, 16'd4);
    vt[7]  = mk(0, 0, 0, 6'd0, 0, 1, 6'd4, 6'd5, 1, 0, 16'd4);
    vt[8]  = mk(0, 0, 0, 6'd0, 0, 1, 6'd4, 6'd5, 1, 0, 16'd4);
    vt[9]  = mk(0, 1, 0, 6'd0, 0, 1, 6'd5, 6'd6, 1, 0, 16'd5);
    vt[10] = mk(0, 1, 0, 6'd0, 0, 1, 6'd6, 6'd7, 1, 0, 16'd6);
    vt[11] = mk(0, 1, 0, 6'd0, 0, 1, 6'd7, 6'd8, 1, 0, 16'd7);
    vt[12] = mk(0, 1, 1, 6'd3, 0, 0, 6'd0, 6'd3, 1, 0, 16'd8);
    vt[13] = mk(0, 1, 0, 6'd0, 0, 1, 6'd3, 6'd4, 1, 0, 16'd8);
    vt[14] = mk(0, 1, 0, 6'd0, 0, 1, 6'd4, 6'd5, 1, 0, 16'd9);
    vt[15] = mk(0, 1, 1, 6'd62, 0, 0, 6'd0, 6'd62, 1, 0, 16'd10);
    vt[16] = mk(0, 1, 0, 6'd0, 0, 1, 6'd62, 6'd63, 1, 0, 16'd10);
    vt[17] = mk(0, 1, 0, 6'd0, 0, 1, 6'd63, 6'd0, 1, 1, 16'd11);
    vt[18] = mk(0, 1, 0, 6'd0, 0, 1, 6'd0, 6'd1, 1, 1, 16'd12);
    vt[19] = mk(0, 1, 0, 6'd0, 0, 1, 6'd1, 6'd2, 1, 1, 16'd13);
    vt[20] = mk(0, 1, 1, 6'd4, 0, 0, 6'd0, 6'd4, 1, 1, 16'd14);
    vt[21] = mk(0, 1, 0, 6'd0, 0, 1, 6'd4, 6'd5, 1, 1, 16'd14);
    vt[22] = mk(0, 1, 0, 6'd0, 0, 1, 6'd5, 6'd6, 1, 1, 16'd15);
    vt[23] = mk(0, 1, 1, 6'd9, 1, 0, 6'd0, 6'd6, 0, 1, 16'd16);
    vt[24] = mk(0, 1, 1, 6'd20, 0, 0, 6'd0, 6'd6, 0, 1, 16'd16);
    vt[25] = mk(1, 1, 0, 6'd0, 0, 0, 6'd0, 6'd0, 1, 1, 16'd16);
    vt[26] = mk(0, 1, 0, 6'd0, 0, 1, 6'd0, 6'd1, 1, 1, 16'd16);
    vt[27] = mk(0, 1, 0, 6'd0, 0, 1, 6'd1, 6'd2, 1, 1, 16'd17);
    vt[28] = mk(1, 1, 0, 6'd0, 0, 1, 6'd2, 6'd3, 1, 1, 16'd18);

    rst = 1'b1; start = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    #12;
    rst = 1'b0;
    tick();
    chk("rst_valid", 0, 32'(instr_valid), 32'd0);
    chk("rst_running", 0, 32'(running), 32'd0);
    chk("rst_pc", 0, 32'(imem_addr), 32'd0);
    chk("rst_count", 0, 32'(fetch_count), 32'd0);
    chk("rst_instr", 0, 32'(instr_out), 32'd0);

    // Idle ignores redirect and halt.
    redirect_valid = 1'b1; redirect_pc = 6'd9; halt_req = 1'b1;
    tick();
    chk("idle_pc", 0, 32'(imem_addr), 32'd0);
    chk("idle_running", 0, 32'(running), 32'd0);
    redirect_valid = 1'b0; halt_req = 1'b0;

    for (int i = 0; i < NV; i++) begin
      start = vt[i].start; instr_ready = vt[i].ready;
      redirect_valid = vt[i].redir; redirect_pc = vt[i].rpc; halt_req = vt[i].halt;
      tick();
      chk("valid", i, 32'(instr_valid), 32'(vt[i].e_valid));
      chk("pc", i, 32'(imem_addr), 32'(vt[i].e_pc));
      chk("running", i, 32'(running), 32'(vt[i].e_run));
      chk("wrapped", i, 32'(pc_wrapped), 32'(vt[i].e_wrap));
      chk("count", i, 32'(fetch_count), 32'(vt[i].e_cnt));
      if (vt[i].e_valid) begin
        chk("instr_pc", i, 32'(instr_pc), 32'(vt[i].e_ipc));
        chk("instr_out", i, 32'(instr_out), 32'(memw(vt[i].e_ipc)));
      end
    end
    start = 1'b0;

    // Asynchronous reset between edges, with start held during reset.
    #3;
    rst = 1'b1;
    start = 1'b1;
    #1;
    chk("arst_valid", 0, 32'(instr_valid), 32'd0);
    chk("arst_running", 0, 32'(running), 32'd0);
    chk("arst_pc", 0, 32'(imem_addr), 32'd0);
    chk("arst_ipc", 0, 32'(instr_pc), 32'd0);
    chk("arst_instr", 0, 32'(instr_out), 32'd0);
    chk("arst_wrap", 0, 32'(pc_wrapped), 32'd0);
    chk("arst_count", 0, 32'(fetch_count), 32'd0);
    tick();
    chk("arst_start_ignored", 0, 32'(running), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("post_rst_idle", 0, 32'(running), 32'd0);

    // Halt while the slot is stalled: nothing accepted, nothing counted.
    start = 1'b1; instr_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk("stall_first_valid", 0, 32'(instr_valid), 32'd1);
    chk("stall_first_instr", 0, 32'(instr_out), 32'(memw(6'd0)));
    tick();
    chk("stall_hold_instr", 0, 32'(instr_out), 32'(memw(6'd0)));
    chk("stall_hold_pc", 0, 32'(imem_addr), 32'd1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_running", 0, 32'(running), 32'd0);
    chk("halt_valid", 0, 32'(instr_valid), 32'd0);
    chk("halt_pc", 0, 32'(imem_addr), 32'd1);
    chk("halt_count", 0, 32'(fetch_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
